// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Purpose:
//   Owns the program counter and sequences a combinational, read-only
//   instruction memory. Each cycle the current PC is presented on imem_addr;
//   when there is room in the instruction buffer (or the head is leaving this
//   cycle) the returned word is captured together with its PC and the PC
//   advances by one word. The buffer feeds decode through a valid/ready
//   handshake. Redirects (branch/jump) flush the buffer and reload the PC;
//   halt freezes fetch while letting decode drain what is already buffered.
//
// Ports:
//   clk            in   1     rising-edge clock
//   rst_n          in   1     asynchronous reset, active-low
//   imem_addr      out  XLEN  byte address to instruction memory (always = pc)
//   imem_rdata     in   XLEN  instruction word for imem_addr, same cycle
//   redirect_valid in   1     load redirect_pc and flush the buffer
//   redirect_pc    in   XLEN  redirect target byte address
//   halt           in   1     level; stop issuing new fetches
//   out_valid      out  1     buffer head holds a valid instruction
//   out_ready      in   1     decode accepts the head this cycle
//   out_instr      out  XLEN  instruction at buffer head
//   out_pc         out  XLEN  PC of out_instr
//   misalign_err   out  1     one-cycle pulse after a misaligned redirect
//   fetch_count    out  32    instructions pushed since reset (wraps)
// ---------------------------------------------------------------------------
module fetch_controller #(
   parameter int               XLEN       = 32,
   parameter logic [XLEN-1:0]  RESET_PC   = '0,
   parameter int               FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            misalign_err,
   output logic [31:0]     fetch_count
);

   localparam int             PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   // Buffer storage, pointers and occupancy
   logic [XLEN-1:0]  r_instrMem [FIFO_DEPTH];
   logic [XLEN-1:0]  r_pcMem    [FIFO_DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   logic [XLEN-1:0]  r_pc;
   logic [31:0]      r_fetchCount;
   logic             r_misalign;

   // Values shown while the buffer is empty (last thing decode saw)
   logic [XLEN-1:0]  r_holdInstr;
   logic [XLEN-1:0]  r_holdPc;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);

   // A departing head frees a slot in the same cycle, so a full buffer can
   // still accept a new word when decode is taking one. Redirect wins over
   // everything: nothing is pushed on the cycle the PC is reloaded.
   assign w_pop  = out_valid & out_ready;
   assign w_push = ~redirect_valid & ~halt & (~w_full | w_pop);

   assign imem_addr    = r_pc;
   assign out_valid    = ~w_empty;
   assign misalign_err = r_misalign;
   assign fetch_count  = r_fetchCount;

   // When empty, the head slot may contain an older entry, so the outputs
   // fall back to the registered copy of whatever was last presented.
   assign out_instr = w_empty ? r_holdInstr : r_instrMem[r_head];
   assign out_pc    = w_empty ? r_holdPc    : r_pcMem[r_head];

   // Storage array carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instrMem[r_tail] <= imem_rdata;
         r_pcMem[r_tail]    <= r_pc;
      end
   end

   // Pointer and occupancy bookkeeping. A redirect discards all buffered
   // entries by returning both pointers and the count to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) begin
            r_head <= r_head + PTR_ONE;
         end
         if (w_push) begin
            r_tail <= r_tail + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Program counter: redirect targets are forced to word alignment; the
   // increment wraps naturally at the top of the address space.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (w_push) begin
         r_pc <= r_pc + XLEN'(4);
      end
   end

   // Push counter, free-running modulo 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetchCount <= '0;
      end else if (w_push) begin
         r_fetchCount <= r_fetchCount + 32'd1;
      end
   end

   // Misalignment flag is recomputed every edge, so it is naturally a
   // single-cycle pulse per offending redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      end
   end

   // Track the presented head every cycle so the outputs can hold it once
   // the buffer empties (by draining or by a flush).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_holdInstr <= '0;
         r_holdPc    <= '0;
      end else begin
         r_holdInstr <= out_instr;
         r_holdPc    <= out_pc;
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//
// Purpose:
//   Drives fetch_controller against a combinational memory whose word k
//   holds k+1, and compares every output each cycle against a queue-based
//   model of the instruction stream. Directed scenarios pin literal values;
//   a randomized phase mixes redirects, halts and back-pressure.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int nChecks = 0;
   int nPass   = 0;
   bit armed   = 1'b0;

   fetch_controller #(
      .XLEN(32),
      .RESET_PC(32'h0),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .halt(halt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
      .misalign_err(misalign_err),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Memory contents: word k holds k+1
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign imem_rdata = memWord(imem_addr);

   // Reference model: a queue of {instr, pc} entries plus a PC, a counter,
   // the last presented entry and the misalign flag.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t      mQ[$];
   entry_t      mLast = '0;
   entry_t      mNew;
   logic [31:0] mPc = '0;
   logic [31:0] mCount = '0;
   bit          mMis = 1'b0;
   int          mSize;
   bit          mPopNow;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mQ.delete();
         mLast  = '0;
         mPc    = '0;
         mCount = '0;
         mMis   = 1'b0;
      end else begin
         if (mQ.size() > 0) mLast = mQ[0];
         if (redirect_valid) begin
            mQ.delete();
            mPc  = {redirect_pc[31:2], 2'b00};
            mMis = (redirect_pc[1:0] != 2'b00);
         end else begin
            mMis    = 1'b0;
            mSize   = mQ.size();
            mPopNow = (mSize > 0) && out_ready;
            if (mPopNow) void'(mQ.pop_front());
            if (!halt && ((mSize < DEPTH) || mPopNow)) begin
               mNew.instr = memWord(mPc);
               mNew.pc    = mPc;
               mQ.push_back(mNew);
               mPc    = mPc + 32'd4;
               mCount = mCount + 32'd1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   entry_t showExp;
   always @(negedge clk) begin
      if (armed && rst_n) begin
         showExp = (mQ.size() > 0) ? mQ[0] : mLast;
         checkOutput("model imem_addr", imem_addr, mPc);
         checkOutput("model out_valid", {31'b0, out_valid}, {31'b0, mQ.size() > 0});
         checkOutput("model out_instr", out_instr, showExp.instr);
         checkOutput("model out_pc", out_pc, showExp.pc);
         checkOutput("model misalign_err", {31'b0, misalign_err}, {31'b0, mMis});
         checkOutput("model fetch_count", fetch_count, mCount);
      end
   end

   // Drive one cycle of inputs, then return just after the following negedge
   task automatic applyStimulus(input bit rv, input logic [31:0] rpc,
                                input bit h, input bit rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt           = h;
      out_ready      = rdy;
      @(negedge clk);
      #2;
   endtask

   // Pulse reset between edges and pin the reset state
   task automatic doReset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset imem_addr", imem_addr, 32'h0);
      checkOutput("reset fetch_count", fetch_count, 32'd0);
      checkOutput("reset misalign_err", {31'b0, misalign_err}, 32'd0);
      checkOutput("reset out_pc", out_pc, 32'h0);
      checkOutput("reset out_instr", out_instr, 32'h0);
      #1;
      rst_n = 1'b1;
      armed = 1'b1;
   endtask

   initial begin
      // Sequential fetch, one instruction per cycle
      out_ready = 1'b1;
      doReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
         checkOutput("seq out_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("seq out_pc", out_pc, 32'(4 * k));
         checkOutput("seq out_instr", out_instr, 32'(k + 1));
      end

      // Back-pressure fills the buffer and freezes the PC
      out_ready = 1'b0;
      doReset();
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("full out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("full out_pc", out_pc, 32'h0);
      checkOutput("full out_instr", out_instr, 32'd1);
      checkOutput("full imem_addr", imem_addr, 32'h8);
      checkOutput("full fetch_count", fetch_count, 32'd2);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("drain1 out_pc", out_pc, 32'h4);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("drain2 out_pc", out_pc, 32'h8);

      // Redirect while full flushes the buffer
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
      checkOutput("redir out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("redir imem_addr", imem_addr, 32'h40);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("redir out_pc", out_pc, 32'h40);
      checkOutput("redir out_instr", out_instr, 32'h11);

      // Misaligned redirect
      applyStimulus(1'b1, 32'h42, 1'b0, 1'b1);
      checkOutput("misalign pulse", {31'b0, misalign_err}, 32'd1);
      checkOutput("misalign imem_addr", imem_addr, 32'h40);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("misalign clear", {31'b0, misalign_err}, 32'd0);
      checkOutput("misalign out_pc", out_pc, 32'h40);

      // Halt drains the buffer and holds the PC and counter
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("halt out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("halt fetch_count", fetch_count, 32'd6);
      checkOutput("halt imem_addr", imem_addr, 32'h44);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("resume out_pc", out_pc, 32'h44);
      checkOutput("resume out_instr", out_instr, 32'h12);
      checkOutput("resume fetch_count", fetch_count, 32'd7);

      // PC wrap at the top of the address space
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      checkOutput("wrap out_valid", {31'b0, out_valid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("wrap out_pc hi", out_pc, 32'hFFFF_FFFC);
      checkOutput("wrap out_instr hi", out_instr, 32'h4000_0000);
      checkOutput("wrap imem_addr", imem_addr, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("wrap out_pc lo", out_pc, 32'h0);
      checkOutput("wrap out_instr lo", out_instr, 32'h1);

      // Randomized mix checked by the model
      for (int k = 0; k < 400; k++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom();
         applyStimulus($urandom_range(0, 15) == 0, rpc,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end

      // Asynchronous reset with a full buffer
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      doReset();
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 32'h0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
